// File: rtl/jtag_reg_bridge.sv
// Debug-transport to register-file bridge: one read or write at a time, with
// writes deferred around core writeback cycles and aborted after RETRY_MAX tries.
module jtag_reg_bridge #(
  parameter int ADDR_W    = 5,
  parameter int DATA_W    = 32,
  parameter int RETRY_MAX = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_data_i,
  output logic              resp_valid_o,
  input  logic              resp_ready_i,
  output logic [DATA_W-1:0] resp_data_o,
  output logic              resp_err_o,
  input  logic              core_we_i,
  input  logic [ADDR_W-1:0] core_waddr_i,
  output logic              regs_we_o,
  output logic [ADDR_W-1:0] regs_addr_o,
  output logic [DATA_W-1:0] regs_wdata_o,
  input  logic [DATA_W-1:0] regs_rdata_i
);

  localparam int CNT_W = $clog2(RETRY_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(RETRY_MAX);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next, cnt_inc;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [DATA_W-1:0] data_reg, data_next;
  logic [DATA_W-1:0] resp_data_reg, resp_data_next;
  logic              resp_err_reg, resp_err_next;
  logic              handshake;
  logic              blocked;

  // A core write to x0 is discarded by the register file, so it cannot collide.
  assign blocked   = core_we_i && (core_waddr_i != '0);
  assign handshake = req_valid_i && (state_reg == IDLE);
  assign cnt_inc   = (cnt_reg == CNT_LIMIT) ? cnt_reg : cnt_reg + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      addr_reg      <= '0;
      data_reg      <= '0;
      resp_data_reg <= '0;
      resp_err_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      addr_reg      <= addr_next;
      data_reg      <= data_next;
      resp_data_reg <= resp_data_next;
      resp_err_reg  <= resp_err_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    addr_next      = addr_reg;
    data_next      = data_reg;
    resp_data_next = resp_data_reg;
    resp_err_next  = resp_err_reg;
    case (state_reg)
      IDLE: begin
        if (handshake) begin
          addr_next = req_addr_i;
          data_next = req_data_i;
          cnt_next  = '0;
          if (!req_we_i) begin
            state_next = READ;
          end else if (req_addr_i == '0) begin
            // x0 is hardwired to zero: acknowledge without touching the port.
            state_next     = RESP;
            resp_data_next = req_data_i;
            resp_err_next  = 1'b0;
          end else begin
            state_next = WRITE;
          end
        end
      end
      READ: begin
        resp_data_next = regs_rdata_i;
        resp_err_next  = 1'b0;
        state_next     = RESP;
      end
      WRITE: begin
        if (!blocked) begin
          resp_data_next = data_reg;
          resp_err_next  = 1'b0;
          state_next     = RESP;
        end else begin
          cnt_next = cnt_inc;
          if (cnt_inc == CNT_LIMIT) begin
            resp_data_next = data_reg;
            resp_err_next  = 1'b1;
            state_next     = RESP;
          end
        end
      end
      RESP: begin
        if (resp_ready_i) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready_o  = (state_reg == IDLE);
    resp_valid_o = (state_reg == RESP);
    // Gated by rst so an abandoned write never reaches the register file.
    regs_we_o    = (state_reg == WRITE) && !blocked && !rst;
    regs_addr_o  = addr_reg;
    regs_wdata_o = data_reg;
    resp_data_o  = resp_data_reg;
    resp_err_o   = resp_err_reg;
  end

endmodule

// File: doc/jtag_reg_bridge.md
Name: jtag_reg_bridge

Overview:
- Sequencer between the debug/JTAG transport and the general-purpose register file's JTAG port (jtag_we/jtag_addr/jtag_data).
- Accepts one read or write request at a time over a valid/ready handshake and drives the register-file debug port.
- Retries writes around core writeback cycles, because the core (ex) write always takes priority and silently drops a concurrent debug write.
- Returns data and an error flag on a valid/ready response channel.

Parameters:
- ADDR_W, 5, register address width (32 GPRs).
- DATA_W, 32, register data width.
- RETRY_MAX, 16, maximum cycles a write waits for a core-idle slot before aborting; legal range 1..255.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- req_valid_i  input  1  debug request valid.
- req_ready_o  output  1  bridge can accept a request.
- req_we_i  input  1  1 = write, 0 = read.
- req_addr_i  input  ADDR_W  target register.
- req_data_i  input  DATA_W  write data.
- resp_valid_o  output  1  response valid.
- resp_ready_i  input  1  response consumed.
- resp_data_o  output  DATA_W  read data, or echo of write data.
- resp_err_o  output  1  write aborted after retry exhaustion.
- core_we_i  input  1  snoop of the core writeback enable (ex).
- core_waddr_i  input  ADDR_W  snoop of the core writeback address.
- regs_we_o  output  1  to the register-file debug write enable.
- regs_addr_o  output  ADDR_W  to the register-file debug read/write address.
- regs_wdata_o  output  DATA_W  to the register-file debug write data.
- regs_rdata_i  input  DATA_W  from the register-file debug read data (combinational; x0 reads 0).

Behaviour:
- Reset: rst sampled on the clk rising edge; takes priority over all inputs.
- Reset state: IDLE, retry counter 0, address/data latches 0, resp_valid_o=0, resp_err_o=0, resp_data_o=0, regs_we_o=0.
- FSM states: IDLE, READ, WRITE, RESP.
- req_ready_o = (state==IDLE). Handshake fires when req_valid_i && req_ready_o.
- IDLE, on handshake: latch we/addr/data; counter is cleared.
  - Read -> READ.
  - Write to addr 0 -> RESP with err=0 and data echo; no port write is issued.
  - Other write -> WRITE.
- regs_addr_o and regs_wdata_o are driven from the latches in every state and hold their values after completion.
- READ lasts exactly 1 cycle. resp_data_o <= regs_rdata_i at the end of that cycle; err=0; next state RESP. Read latency is 2 cycles from handshake to resp_valid_o.
- Reads return the stored register value: there is no bypass of a same-cycle core write.
- WRITE, per cycle, with blocked = core_we_i && (core_waddr_i != 0):
  - Not blocked: regs_we_o=1 for exactly that cycle; resp_data_o <= latched data; err=0; next state RESP.
  - Blocked: regs_we_o=0 and the counter increments.
  - Abort: if the counter reaches RETRY_MAX while still blocked, go to RESP with err=1 and data echo. No write occurs.
- Best case write latency is 2 cycles from handshake to resp_valid_o.
- regs_we_o is combinational in WRITE (not blocked) and is never 1 in any other state.
- RESP: resp_valid_o=1, and resp_data_o/resp_err_o stay stable until resp_ready_i. The cycle resp_ready_i=1 returns to IDLE; resp_valid_o drops the next cycle.
- A new request cannot be accepted in the same cycle as a response handshake.
- Counter width is $clog2(RETRY_MAX+1) and it saturates (no wrap).
- rst asserted mid-operation (READ/WRITE/RESP): the transaction is abandoned with no response and no write issued after the reset edge; the bridge returns to IDLE.

Test Plan:
- Read: after reset, request read addr 5 with reg5 = 0xDEADBEEF; core idle -> resp_valid_o=1 two cycles after handshake, resp_data_o=0xDEADBEEF, err=0.
- Write, core idle: write 0x12345678 to addr 7 -> regs_we_o pulses 1 cycle with regs_addr_o=7; response err=0; a subsequent read of addr 7 returns 0x12345678.
- Write deferral: hold core_we_i=1 with core_waddr_i=3 for 4 cycles, then release; write 0xA5A5A5A5 to addr 9 -> regs_we_o=0 for 4 cycles, then 1; response err=0; reg9=0xA5A5A5A5.
- Retry exhaustion: RETRY_MAX=4 with core_we_i=1, core_waddr_i=1 held continuously; write to addr 2 -> regs_we_o never asserts; resp_err_o=1 after 4 blocked cycles; reg2 unchanged.
- Core writing x0: core_we_i=1 with core_waddr_i=0 -> the write is not blocked and completes in the first WRITE cycle. Separately, a write to addr 0 -> no regs_we_o, err=0, reading addr 0 returns 0.
- Backpressure and reset: hold resp_ready_i=0 for 5 cycles -> resp_valid_o, data and err stay stable and req_ready_o=0. Then assert rst for 1 cycle during WRITE -> IDLE, req_ready_o=1, resp_valid_o=0, and no write issued.
